// File: rtl/sweep_scheduler.sv
// Sequences the neighbour-search datapath: steps target batches over the cloud,
// sweeps feeder windows per batch and queues outlier indices in a show-ahead FIFO.
module sweep_scheduler #(
    parameter int N           = 16,
    parameter int M           = 32,
    parameter int CORE_NUMBER = 2,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [N-1:0]           point_cloud_size,
    output logic [N-1:0]           point_pos,
    output logic [N-1:0]           feeder_pos,
    output logic                   window_valid,
    output logic                   last_window,
    output logic                   core_clear,
    input  logic                   core_result_valid,
    input  logic [CORE_NUMBER-1:0] core_outlier,
    input  logic                   read_fifo,
    output logic [N-1:0]           outlier_pos_fifo,
    output logic                   empty,
    output logic                   full,
    output logic                   busy,
    output logic                   done
);

    localparam int LW = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [N:0]    M_EXT  = (N+1)'(M);
    localparam logic [N:0]    CN_EXT = (N+1)'(CORE_NUMBER);
    localparam logic [LW-1:0] LANE_LAST = LW'(CORE_NUMBER - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_SWEEP   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_PUSH    = 3'd4;
    localparam logic [2:0] S_ADVANCE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]             state_q, state_d;
    logic [N-1:0]           size_q, size_d;
    logic [N-1:0]           point_pos_q, point_pos_d;
    logic [N-1:0]           feeder_pos_q, feeder_pos_d;
    logic [CORE_NUMBER-1:0] mask_q, mask_d;
    logic [LW-1:0]          lane_q, lane_d;

    logic [N-1:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;

    logic [N:0]   size_ext;
    logic [N:0]   feeder_next;
    logic [N:0]   point_next;
    logic [N-1:0] lane_idx;
    logic         last_hit;
    logic         fifo_empty;
    logic         fifo_full;
    logic         pop;
    logic         push;
    logic         lane_hit;
    logic         flush;

    // All bounds checks use one extra bit so base+offset can never wrap.
    assign size_ext    = {1'b0, size_q};
    assign feeder_next = {1'b0, feeder_pos_q} + M_EXT;
    assign point_next  = {1'b0, point_pos_q} + CN_EXT;
    assign lane_idx    = point_pos_q + N'(lane_q);
    assign last_hit    = (feeder_next >= size_ext);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign pop        = read_fifo && !fifo_empty;
    assign lane_hit   = mask_q[lane_q];
    // A full FIFO still accepts a push when the same cycle pops the head.
    assign push       = (state_q == S_PUSH) && lane_hit && (!fifo_full || read_fifo);
    assign flush      = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        point_pos_d  = point_pos_q;
        feeder_pos_d = feeder_pos_q;
        mask_d       = mask_q;
        lane_d       = lane_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    size_d      = point_cloud_size;
                    point_pos_d = '0;
                    if (point_cloud_size == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_CLEAR;
                        feeder_pos_d = '0;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_SWEEP;
            end
            S_SWEEP: begin
                if (last_hit) begin
                    state_d = S_WAIT;
                end else begin
                    feeder_pos_d = feeder_next[N-1:0];
                end
            end
            S_WAIT: begin
                if (core_result_valid) begin
                    for (int unsigned i = 0; i < CORE_NUMBER; i++) begin
                        mask_d[i] = core_outlier[i] &&
                                    (({1'b0, point_pos_q} + (N+1)'(i)) < size_ext);
                    end
                    lane_d  = '0;
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (!lane_hit || push) begin
                    if (lane_q == LANE_LAST) begin
                        state_d = S_ADVANCE;
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            S_ADVANCE: begin
                point_pos_d = point_next[N-1:0];
                if (point_next >= size_ext) begin
                    state_d = S_DONE;
                end else begin
                    state_d      = S_CLEAR;
                    feeder_pos_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            size_q       <= '0;
            point_pos_q  <= '0;
            feeder_pos_q <= '0;
            mask_q       <= '0;
            lane_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            point_pos_q  <= point_pos_d;
            feeder_pos_q <= feeder_pos_d;
            mask_q       <= mask_d;
            lane_q       <= lane_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: the head is only shown while the FIFO is non-empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= lane_idx;
        end
    end

    assign point_pos        = point_pos_q;
    assign feeder_pos       = feeder_pos_q;
    assign window_valid     = (state_q == S_SWEEP);
    assign last_window      = (state_q == S_SWEEP) && last_hit;
    assign core_clear       = (state_q == S_CLEAR);
    assign outlier_pos_fifo = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign empty            = fifo_empty;
    assign full             = fifo_full;
    assign busy             = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done             = (state_q == S_DONE);

endmodule

// File: tb/tb_sweep_scheduler.sv
// Bench for sweep_scheduler: instance 0 uses a 16-entry FIFO, instance 1 a 4-entry FIFO.
module tb_sweep_scheduler;

    localparam int N  = 16;
    localparam int M  = 32;
    localparam int CN = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_s [2];
    logic [N-1:0]  size_s  [2];
    logic          rv_s    [2];
    logic          rd_s    [2];
    logic [CN-1:0] outl_s  [2];

    logic [N-1:0]  pp_o   [2];
    logic [N-1:0]  fp_o   [2];
    logic [N-1:0]  head_o [2];
    logic          wv_o   [2];
    logic          lw_o   [2];
    logic          cc_o   [2];
    logic          emp_o  [2];
    logic          ful_o  [2];
    logic          bsy_o  [2];
    logic          dn_o   [2];

    int mode [2];
    int nerr = 0;
    int nchk = 0;
    int cc_cnt [2] = '{0, 0};
    int wv_cnt [2] = '{0, 0};

    sweep_scheduler #(.N(N), .M(M), .CORE_NUMBER(CN), .FIFO_DEPTH(16)) u_a (
        .clock(clk), .reset(rst_n), .start(start_s[0]), .point_cloud_size(size_s[0]),
        .point_pos(pp_o[0]), .feeder_pos(fp_o[0]), .window_valid(wv_o[0]),
        .last_window(lw_o[0]), .core_clear(cc_o[0]), .core_result_valid(rv_s[0]),
        .core_outlier(outl_s[0]), .read_fifo(rd_s[0]), .outlier_pos_fifo(head_o[0]),
        .empty(emp_o[0]), .full(ful_o[0]), .busy(bsy_o[0]), .done(dn_o[0])
    );

    sweep_scheduler #(.N(N), .M(M), .CORE_NUMBER(CN), .FIFO_DEPTH(4)) u_b (
        .clock(clk), .reset(rst_n), .start(start_s[1]), .point_cloud_size(size_s[1]),
        .point_pos(pp_o[1]), .feeder_pos(fp_o[1]), .window_valid(wv_o[1]),
        .last_window(lw_o[1]), .core_clear(cc_o[1]), .core_result_valid(rv_s[1]),
        .core_outlier(outl_s[1]), .read_fifo(rd_s[1]), .outlier_pos_fifo(head_o[1]),
        .empty(emp_o[1]), .full(ful_o[1]), .busy(bsy_o[1]), .done(dn_o[1])
    );

    function automatic int depth_of(input int u);
        return (u == 0) ? 16 : 4;
    endfunction

    function automatic int nwin(input int s);
        return (s + M - 1) / M;
    endfunction

    task automatic cmp(input string nm, input int u, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            if (nerr <= 40)
                $display("FAIL %s inst%0d t=%0t got=%0d expected=%0d", nm, u, $time, got, exp);
        end
    endtask

    // Behavioural model: batch/cycle counters plus a ring-buffer FIFO per instance.
    bit m_run [2], m_done [2], m_got [2];
    int m_pp [2], m_fp [2], m_S [2], m_cyc [2], m_lane [2];
    bit [CN-1:0] m_mask [2];
    int mf [2][16];
    int mhead [2], mcnt [2];

    always @(posedge clk or negedge rst_n) begin : model
        int w, dep, pv;
        bit pop, psh;
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                m_run[u] = 0; m_done[u] = 0; m_got[u] = 0;
                m_pp[u] = 0; m_fp[u] = 0; m_S[u] = 0; m_cyc[u] = 0; m_lane[u] = 0;
                m_mask[u] = '0; mhead[u] = 0; mcnt[u] = 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                dep = depth_of(u);
                w   = nwin(m_S[u]);
                pop = rd_s[u] && (mcnt[u] > 0);
                psh = 0;
                pv  = 0;
                if (!m_run[u]) begin
                    if (start_s[u]) begin
                        mcnt[u] = 0; mhead[u] = 0; pop = 0;
                        m_S[u] = int'(size_s[u]);
                        m_pp[u] = 0;
                        if (m_S[u] == 0) begin
                            m_done[u] = 1;
                        end else begin
                            m_done[u] = 0; m_run[u] = 1; m_cyc[u] = 0; m_fp[u] = 0;
                        end
                    end
                end else if (m_cyc[u] == 0) begin
                    m_cyc[u] = 1;
                end else if (m_cyc[u] <= w) begin
                    if (m_cyc[u] < w) m_fp[u] += M;
                    m_cyc[u]++;
                    m_got[u] = 0;
                end else if (!m_got[u]) begin
                    if (rv_s[u]) begin
                        m_got[u] = 1;
                        m_lane[u] = 0;
                        for (int i = 0; i < CN; i++)
                            m_mask[u][i] = outl_s[u][i] && (m_pp[u] + i < m_S[u]);
                    end
                end else if (m_lane[u] < CN) begin
                    if (!m_mask[u][m_lane[u]]) begin
                        m_lane[u]++;
                    end else if (mcnt[u] < dep || rd_s[u]) begin
                        psh = 1;
                        pv  = m_pp[u] + m_lane[u];
                        m_lane[u]++;
                    end
                end else begin
                    m_pp[u] += CN;
                    if (m_pp[u] >= m_S[u]) begin
                        m_run[u] = 0; m_done[u] = 1;
                    end else begin
                        m_cyc[u] = 0; m_fp[u] = 0;
                    end
                end
                if (pop) begin
                    mhead[u] = (mhead[u] + 1) % dep;
                    mcnt[u]--;
                end
                if (psh) begin
                    mf[u][(mhead[u] + mcnt[u]) % dep] = pv;
                    mcnt[u]++;
                end
            end
        end
    end

    // Core verdict generator, keyed to the batch the model expects.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            case (mode[u])
                1:       outl_s[u] = '1;
                2:       outl_s[u] = (m_pp[u] == 4) ? '1 : '0;
                default: outl_s[u] = '0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int u = 0; u < 2; u++) begin
                automatic int  w   = nwin(m_S[u]);
                automatic bit  ewv = m_run[u] && (m_cyc[u] >= 1) && (m_cyc[u] <= w);
                automatic bit  elw = ewv && (m_cyc[u] == w);
                automatic bit  ecc = m_run[u] && (m_cyc[u] == 0);
                automatic int  eh  = (mcnt[u] == 0) ? 0 : mf[u][mhead[u]];
                cmp("point_pos", u, 32'(pp_o[u]), m_pp[u]);
                cmp("feeder_pos", u, 32'(fp_o[u]), m_fp[u]);
                cmp("window_valid", u, 32'(wv_o[u]), 32'(ewv));
                cmp("last_window", u, 32'(lw_o[u]), 32'(elw));
                cmp("core_clear", u, 32'(cc_o[u]), 32'(ecc));
                cmp("busy", u, 32'(bsy_o[u]), 32'(m_run[u]));
                cmp("done", u, 32'(dn_o[u]), 32'(m_done[u]));
                cmp("empty", u, 32'(emp_o[u]), 32'(mcnt[u] == 0));
                cmp("full", u, 32'(ful_o[u]), 32'(mcnt[u] == depth_of(u)));
                cmp("fifo_head", u, 32'(head_o[u]), eh);
                cc_cnt[u] += int'(cc_o[u]);
                wv_cnt[u] += int'(wv_o[u]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int u, input int sz);
        start_s[u] = 1'b1;
        size_s[u]  = N'(sz);
        @(negedge clk);
        start_s[u] = 1'b0;
    endtask

    task automatic wait_done(input int u, input int lim, input bit rand_rv);
        int k = 0;
        while (!dn_o[u] && k < lim) begin
            @(negedge clk);
            if (rand_rv) rv_s[u] = 1'($urandom_range(0, 1));
            k++;
        end
        cmp("done_within_budget", u, 32'(dn_o[u]), 1);
    endtask

    task automatic pop_one(input int u);
        rd_s[u] = 1'b1;
        @(negedge clk);
        rd_s[u] = 1'b0;
    endtask

    initial begin
        int c0, w0, k;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0; size_s[u] = '0; rv_s[u] = 1'b1; rd_s[u] = 1'b0; mode[u] = 0;
        end
        tick(2);
        for (int u = 0; u < 2; u++) begin
            cmp("rst_empty", u, 32'(emp_o[u]), 1);
            cmp("rst_busy", u, 32'(bsy_o[u]), 0);
            cmp("rst_done", u, 32'(dn_o[u]), 0);
            cmp("rst_point_pos", u, 32'(pp_o[u]), 0);
            cmp("rst_window_valid", u, 32'(wv_o[u]), 0);
        end
        rst_n = 1'b1;
        tick(1);

        // Size 64, no outliers: 32 batches of two windows each.
        c0 = cc_cnt[0]; w0 = wv_cnt[0];
        pulse_start(0, 64);
        wait_done(0, 2000, 0);
        cmp("t1_point_pos_final", 0, 32'(pp_o[0]), 64);
        cmp("t1_batches", 0, cc_cnt[0] - c0, 32);
        cmp("t1_windows", 0, wv_cnt[0] - w0, 64);
        cmp("t1_empty", 0, 32'(emp_o[0]), 1);

        // Outliers only at batch 4.
        mode[0] = 2;
        pulse_start(0, 64);
        wait_done(0, 2000, 0);
        cmp("t2_head_first", 0, 32'(head_o[0]), 4);
        pop_one(0);
        cmp("t2_head_second", 0, 32'(head_o[0]), 5);
        pop_one(0);
        cmp("t2_empty_after_reads", 0, 32'(emp_o[0]), 1);

        // Size 5, all outliers, result_valid toggling: index 5 must be masked.
        mode[0] = 1;
        w0 = wv_cnt[0];
        pulse_start(0, 5);
        wait_done(0, 2000, 1);
        rv_s[0] = 1'b1;
        cmp("t3_windows", 0, wv_cnt[0] - w0, 3);
        cmp("t3_point_pos_final", 0, 32'(pp_o[0]), 6);
        for (int i = 0; i < 5; i++) begin
            cmp("t3_drain", 0, 32'(head_o[0]), i);
            pop_one(0);
        end
        cmp("t3_empty", 0, 32'(emp_o[0]), 1);

        // 4-deep FIFO, size 8, all outliers: stall on full, drained one at a time.
        mode[1] = 1;
        pulse_start(1, 8);
        k = 0;
        while (!ful_o[1] && k < 200) begin @(negedge clk); k++; end
        cmp("t4_full", 1, 32'(ful_o[1]), 1);
        tick(6);
        cmp("t4_stall_busy", 1, 32'(bsy_o[1]), 1);
        cmp("t4_stall_full", 1, 32'(ful_o[1]), 1);
        cmp("t4_stall_point_pos", 1, 32'(pp_o[1]), 4);
        for (int i = 0; i < 8; i++) begin
            k = 0;
            while (emp_o[1] && k < 200) begin @(negedge clk); k++; end
            cmp("t4_drain", 1, 32'(head_o[1]), i);
            pop_one(1);
        end
        wait_done(1, 200, 0);
        cmp("t4_empty", 1, 32'(emp_o[1]), 1);
        cmp("t4_point_pos_final", 1, 32'(pp_o[1]), 8);

        // Asynchronous reset in the middle of a sweep.
        pulse_start(0, 64);
        k = 0;
        while (!(wv_o[0] && pp_o[0] == 2) && k < 200) begin @(negedge clk); k++; end
        cmp("t5_reached_sweep", 0, 32'(wv_o[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        cmp("t5_window_valid", 0, 32'(wv_o[0]), 0);
        cmp("t5_busy", 0, 32'(bsy_o[0]), 0);
        cmp("t5_done", 0, 32'(dn_o[0]), 0);
        cmp("t5_empty", 0, 32'(emp_o[0]), 1);
        cmp("t5_point_pos", 0, 32'(pp_o[0]), 0);
        cmp("t5_feeder_pos", 0, 32'(fp_o[0]), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick(1);

        // Empty cloud: done next cycle, no clear, no windows.
        mode[0] = 0;
        c0 = cc_cnt[0]; w0 = wv_cnt[0];
        pulse_start(0, 0);
        cmp("t6_done", 0, 32'(dn_o[0]), 1);
        cmp("t6_busy", 0, 32'(bsy_o[0]), 0);
        tick(4);
        cmp("t6_no_clear", 0, cc_cnt[0] - c0, 0);
        cmp("t6_no_window", 0, wv_cnt[0] - w0, 0);

        // A start while busy must not restart the run.
        pulse_start(0, 64);
        k = 0;
        while (pp_o[0] != 4 && k < 200) begin @(negedge clk); k++; end
        pulse_start(0, 8);
        wait_done(0, 3000, 0);
        cmp("t5_start_ignored_final_pos", 0, 32'(pp_o[0]), 64);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sweep_scheduler.md
Name: sweep_scheduler

Overview:
- Sequences the neighbour-search datapath of the LiDAR outlier-removal engine.
- Steps the target batch index (point_pos) over the cloud, CORE_NUMBER points per batch.
- For each batch, sweeps the feeder window (feeder_pos) over the whole cloud in strides of M.
- Collects per-core outlier verdicts and queues the outlier indices in an internal show-ahead FIFO, which the host drains once done is asserted.

Parameters:
N, 16, index / coordinate width
M, 32, feeder window stride (points per window)
CORE_NUMBER, 2, target points evaluated in parallel per batch
FIFO_DEPTH, 16, outlier FIFO entries (power of 2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins a run
point_cloud_size  input  N  points in cloud; sampled on accepted start
point_pos  output  N  base index of current target batch
feeder_pos  output  N  base index of current feeder window
window_valid  output  1  feeder window at feeder_pos is valid this cycle
last_window  output  1  current window is the final one of the sweep
core_clear  output  1  one-cycle pulse; cores clear neighbour counters
core_result_valid  input  1  cores present verdicts this cycle
core_outlier  input  CORE_NUMBER  bit i = verdict for point point_pos+i
read_fifo  input  1  pop FIFO head
outlier_pos_fifo  output  N  FIFO head; 0 when empty
empty  output  1  FIFO empty
full  output  1  FIFO full
busy  output  1  run in progress (state not IDLE/DONE)
done  output  1  run complete; held until next start

Behaviour:
- Reset (async, reset=0): state IDLE; all counters and outputs 0; FIFO flushed; empty=1.
- All arithmetic and comparisons are done in N+1 bits so sums never wrap. size is the latched point_cloud_size.
- IDLE/DONE + start:
  - flush FIFO; latch size; point_pos=0; done=0.
  - If size==0, go to DONE next cycle with no windows issued. Otherwise go to CLEAR.
- start is ignored while busy.
- CLEAR: core_clear=1 for one cycle; feeder_pos=0; next state SWEEP.
- SWEEP:
  - window_valid=1 every cycle.
  - last_window=1 when feeder_pos+M >= size.
  - If not the last window, feeder_pos += M next cycle. On the last window, go to WAIT_RES and hold feeder_pos.
  - Windows = ceil(size/M). Cores mask feeder lanes >= size.
- WAIT_RES:
  - Wait indefinitely for core_result_valid.
  - Latch mask = core_outlier with bit i cleared when point_pos+i >= size.
  - Go to PUSH with lane k=0.
  - core_result_valid outside WAIT_RES is ignored.
- PUSH:
  - One lane per cycle, k = 0..CORE_NUMBER-1.
  - If mask[k]=0, skip the lane.
  - If mask[k]=1, write point_pos+k into the FIFO. If full=1 and read_fifo=0 that cycle, stall on lane k.
  - After lane CORE_NUMBER-1 is handled, go to ADVANCE.
- ADVANCE: point_pos += CORE_NUMBER. If the new point_pos >= size, go to DONE; else go to CLEAR.
- DONE: done=1, busy=0; point_pos holds its last incremented value.
- FIFO:
  - Show-ahead: outlier_pos_fifo shows the head combinationally from registered storage; the pop takes effect at the next edge.
  - read_fifo is accepted in any state; read when empty is ignored.
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - Entries leave in push order (ascending index).
- Per batch, cycles = 1 + windows + result wait + CORE_NUMBER (+ stalls) + 1.

Test Plan:
1. size=64, M=32, CN=2, core_outlier=0, results 1 cycle after last_window:
   - feeder_pos sequence per batch is 0,32, with last_window on 32;
   - point_pos takes 0,2,…,62;
   - done after 32 batches; empty stays 1.
2. size=64, core_outlier=2'b11 only when point_pos=4, no reads:
   - FIFO holds 4 then 5;
   - outlier_pos_fifo=4; after one read_fifo it equals 5; after a second read, empty=1.
3. size=5, core_outlier=2'b11 every batch:
   - one window per batch (feeder_pos=0, last_window=1);
   - FIFO holds 0,1,2,3,4; index 5 is never pushed.
4. FIFO_DEPTH=4, size=8, all outliers, no reads:
   - full=1 after 4 entries; scheduler stalls in PUSH with busy=1;
   - each read_fifo releases one push; final drain order is 0..7.
5. reset pulled low mid-SWEEP:
   - immediately window_valid=0, busy=0, done=0, empty=1, point_pos=0, feeder_pos=0;
   - a start pulse while busy in a separate run is ignored (point_pos unaffected).
6. size=0, start pulse:
   - done=1 on the following cycle;
   - window_valid and core_clear are never asserted.
